// File: rtl/ucounter16_seq_pkg.sv
// Shared types for the ucounter16 command sequencer: command opcodes,
// completion status codes and FSM state encoding.
package ucounter16_seq_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR   = 2'b00,
        OP_LOAD    = 2'b01,
        OP_RUN_TO  = 2'b10,
        OP_RUN_OVF = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_OVERFLOW = 2'b01,
        ST_TIMEOUT  = 2'b10
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // True for the two opcodes that let the counter free-run.
    function automatic logic is_run_op(input op_e op);
        return (op == OP_RUN_TO) || (op == OP_RUN_OVF);
    endfunction

endpackage

// File: rtl/ucounter16_seq_watchdog.sv
// Cycle counter that bounds how long a RUN command may last. Cleared while
// the sequencer is not running, counts once per RUN cycle, and flags the
// last permitted cycle so the sequencer can abort in that same cycle.
import ucounter16_seq_pkg::*;

module ucounter16_seq_watchdog #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 16'hFFFF
) (
    input  logic clk,
    input  logic _reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins over enable; otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/ucounter16_seq.sv
// Command sequencer for one ucounter16. Accepts CLEAR / LOAD / RUN_TO /
// RUN_OVF commands over valid/ready, steers the counter's active-low control
// pins, freezes the counter on target, overflow or watchdog expiry, and
// reports the final count with a status code through a one-cycle done pulse.
import ucounter16_seq_pkg::*;

module ucounter16_seq #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic             cmd_wrap,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       status,
    output logic             _cnt_areset,
    output logic             _cnt_aset,
    output logic             _cnt_load,
    output logic [WIDTH-1:0] cnt_preld_val,
    output logic             _cnt_updown,
    output logic             _cnt_wrapstop,
    input  logic [WIDTH-1:0] cnt_dcount,
    input  logic             cnt_overflow
);

    state_e           state_q,  state_d;
    op_e              op_q,     op_d;
    logic             dir_q,    dir_d;
    logic             wrap_q,   wrap_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic [WIDTH-1:0] hold_q,   hold_d;
    logic [WIDTH-1:0] result_q, result_d;
    status_e          status_q, status_d;

    logic             areset_n;
    logic             load_n;
    logic [WIDTH-1:0] preld;
    logic             wd_clear;
    logic             wd_en;
    logic             wd_expired;
    logic             hit_target;
    logic             hit_ovf;

    ucounter16_seq_watchdog #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        ._reset  (_reset),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    // RUN exit conditions; overflow is ignored only for RUN_TO in wrap mode.
    assign hit_target = (op_q == OP_RUN_TO) && (cnt_dcount == data_q);
    assign hit_ovf    = cnt_overflow && ((op_q == OP_RUN_OVF) || !wrap_q);

    // Next-state, register updates and counter pin control.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dir_d    = dir_q;
        wrap_d   = wrap_q;
        data_d   = data_q;
        hold_d   = hold_q;
        result_d = result_q;
        status_d = status_q;
        areset_n = 1'b1;
        load_n   = 1'b0;       // default: counter reloads its own held value
        preld    = hold_q;
        wd_clear = 1'b1;
        wd_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = op_e'(cmd_op);
                    dir_d  = cmd_dir;
                    wrap_d = cmd_wrap;
                    data_d = cmd_data;
                    if (is_run_op(op_e'(cmd_op))) begin
                        state_d = S_RUN;
                    end else if (op_e'(cmd_op) == OP_LOAD) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                areset_n = 1'b0;
                preld    = '0;
                hold_d   = '0;
                result_d = '0;
                status_d = ST_OK;
                state_d  = S_DONE;
            end
            S_LOAD: begin
                preld    = data_q;
                hold_d   = data_q;
                result_d = data_q;
                status_d = ST_OK;
                state_d  = S_DONE;
            end
            S_RUN: begin
                load_n   = 1'b1;
                wd_clear = 1'b0;
                wd_en    = 1'b1;
                if (hit_target || hit_ovf || wd_expired) begin
                    // Freeze on the exiting value so the counter never overshoots.
                    load_n   = 1'b0;
                    preld    = cnt_dcount;
                    hold_d   = cnt_dcount;
                    result_d = cnt_dcount;
                    state_d  = S_DONE;
                    if (hit_target) begin
                        status_d = ST_OK;
                    end else if (hit_ovf) begin
                        status_d = ST_OVERFLOW;
                    end else begin
                        status_d = ST_TIMEOUT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_CLEAR;
            dir_q    <= 1'b0;
            wrap_q   <= 1'b0;
            data_q   <= '0;
            hold_q   <= '0;
            result_q <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dir_q    <= dir_d;
            wrap_q   <= wrap_d;
            data_q   <= data_d;
            hold_q   <= hold_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    assign cmd_ready     = _reset && (state_q == S_IDLE);
    assign busy          = (state_q == S_CLEAR) || (state_q == S_LOAD) || (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign result        = result_q;
    assign status        = status_q;
    assign _cnt_areset   = _reset && areset_n;
    assign _cnt_aset     = 1'b1;
    assign _cnt_load     = load_n;
    assign cnt_preld_val = preld;
    assign _cnt_updown   = dir_q;
    assign _cnt_wrapstop = wrap_q;

endmodule
